cache_ctrl_wb: RTL and testbench

Parametrised write-back cache controller: successor to the single-purpose instruction-cache fill FSM. Sits between a CPU port (read/write, word-addressed) and a direct-mapped cache array plus line-wide main memory. Serves read and write hits in the request cycle, evicts dirty victims before allocating on a miss, and merges write data into freshly filled lines. Line width, address split and tag width are parameters.

---
 rtl/cache_ctrl_wb.sv | 171 +++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_ctrl_wb : direct-mapped write-back cache controller (compare/evict/fill)
// Optional macro CACHE_CTRL_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cache_ctrl_wb #(
  parameter  int ADDR_W = 16,
  parameter  int TAG_W  = 8,
  parameter  int WORDS  = 4,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int IDX_W  = ADDR_W - TAG_W - OFF_W,
  localparam int LINE_W = 16 * WORDS,
  localparam int MA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wrt_data,
  output logic              rdy,
  output logic [OFF_W-1:0]  sel,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic [TAG_W-1:0]  c_tag,
  input  logic [LINE_W-1:0] c_rd_line,
  output logic              c_we,
  output logic [LINE_W-1:0] c_wr_line,
  output logic              c_dirty_out,
  output logic              m_re,
  output logic              m_we,
  output logic [MA_W-1:0]   m_addr,
  output logic [LINE_W-1:0] m_wr_data,
  input  logic [LINE_W-1:0] m_rd_data,
`ifdef CACHE_CTRL_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  input  logic              m_rdy
);

  typedef enum logic [1:0] {
    COMPARE    = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t            state;
  logic [MA_W-1:0]   vic_addr;
  logic [LINE_W-1:0] vic_line;

  logic              req;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [MA_W-1:0]   line_addr;

  assign req       = re | we;
  assign off       = addr[OFF_W-1:0];
  assign idx       = addr[OFF_W +: IDX_W];
  assign line_addr = addr[ADDR_W-1:OFF_W];

  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0] line,
    input logic [OFF_W-1:0]  word,
    input logic [15:0]       data
  );
    logic [LINE_W-1:0] res;
    res = line;
    res[{word, 4'b0000} +: 16] = data;
    return res;
  endfunction

  // Victim address/data are captured on the compare cycle so the write-back
  // stays stable even though the cache array output follows addr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COMPARE;
      vic_addr <= '0;
      vic_line <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (req && !c_hit) begin
            if (c_dirty) begin
              vic_addr <= {c_tag, idx};
              vic_line <= c_rd_line;
              state    <= WRITE_BACK;
            end else begin
              state <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: if (m_rdy) state <= ALLOCATE;
        ALLOCATE:   if (m_rdy) state <= COMPARE;
        default:    state <= COMPARE;
      endcase
    end
  end

  always_comb begin
    rdy         = 1'b0;
    sel         = '0;
    c_we        = 1'b0;
    c_wr_line   = '0;
    c_dirty_out = 1'b0;
    m_re        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wr_data   = '0;
    case (state)
      COMPARE: begin
        if (req) begin
          if (c_hit) begin
            rdy = 1'b1;
            if (we) begin
              c_we        = 1'b1;
              c_wr_line   = merge_word(c_rd_line, off, wrt_data);
              c_dirty_out = 1'b1;
            end else begin
              sel = off;
            end
          end else if (c_dirty) begin
            m_we      = 1'b1;
            m_addr    = {c_tag, idx};
            m_wr_data = c_rd_line;
          end else begin
            m_re   = 1'b1;
            m_addr = line_addr;
          end
        end
      end
      WRITE_BACK: begin
        m_we      = 1'b1;
        m_addr    = vic_addr;
        m_wr_data = vic_line;
      end
      ALLOCATE: begin
        m_re   = 1'b1;
        m_addr = line_addr;
        if (m_rdy) begin
          c_we        = 1'b1;
          c_wr_line   = we ? merge_word(m_rd_data, off, wrt_data) : m_rd_data;
          c_dirty_out = we;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  logic after_fill;

  // The rdy that completes a miss is the replayed hit, so it is not a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= (state == ALLOCATE) && m_rdy;
      if (rdy && !after_fill && (hit_cnt != 16'hFFFF))
        hit_cnt <= hit_cnt + 16'd1;
      if ((state == COMPARE) && req && !c_hit && (miss_cnt != 16'hFFFF))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_ctrl_wb : self-checking bench for cache_ctrl_wb (default parameters)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cache_ctrl_wb;

  typedef struct packed {
    logic [63:0] line;
    logic        dirty;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        re, we;
  logic [15:0] addr;
  logic [15:0] wrt_data;
  logic        rdy;
  logic [1:0]  sel;
  logic        c_hit, c_dirty;
  logic [7:0]  c_tag;
  logic [63:0] c_rd_line;
  logic        c_we;
  logic [63:0] c_wr_line;
  logic        c_dirty_out;
  logic        m_re, m_we;
  logic [13:0] m_addr;
  logic [63:0] m_wr_data;
  logic [63:0] m_rd_data;
  logic        m_rdy;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];

  cache_ctrl_wb dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wrt_data(wrt_data),
    .rdy(rdy), .sel(sel), .c_hit(c_hit), .c_dirty(c_dirty), .c_tag(c_tag),
    .c_rd_line(c_rd_line), .c_we(c_we), .c_wr_line(c_wr_line), .c_dirty_out(c_dirty_out),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data),
`ifdef CACHE_CTRL_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .m_rdy(m_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    re = 0; we = 0; addr = 0; wrt_data = 0;
    c_hit = 0; c_dirty = 0; c_tag = 0; c_rd_line = 0;
    m_rd_data = 0; m_rdy = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 0; drive_idle();
    @(negedge clk); @(negedge clk); rst_n = 1; #2;
    tests++;
    if ({rdy, c_we, c_dirty_out, m_re, m_we} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {rdy, c_we, c_dirty_out, m_re, m_we});
    end
    tests++;
    if (sel !== 2'b0 || m_addr !== 14'h0) begin
      fails++; $display("FAIL reset_addr: sel=%h m_addr=%h expected 0", sel, m_addr);
    end
    tests++;
    if (c_wr_line !== 64'h0 || m_wr_data !== 64'h0) begin
      fails++; $display("FAIL reset_data: c_wr_line=%h m_wr_data=%h expected 0", c_wr_line, m_wr_data);
    end
    // Cache/memory status with no request must not start anything.
    @(negedge clk); c_hit = 1; c_dirty = 1; m_rdy = 1; c_rd_line = 64'h1234; #2;
    tests++;
    if ({rdy, c_we, m_re, m_we} !== 4'b0) begin
      fails++; $display("FAIL idle_no_req: got %b expected 0000", {rdy, c_we, m_re, m_we});
    end
    @(negedge clk); drive_idle(); #2;
    tests++;
    if ({m_re, m_we} !== 2'b0) begin
      fails++; $display("FAIL idle_m_rdy_ignored: m_re/m_we=%b expected 00", {m_re, m_we});
    end
  endtask

  task automatic test_read_hit();
    @(negedge clk); drive_idle();
    addr = 16'h12C6; re = 1; c_hit = 1; c_rd_line = 64'h0123_4567_89AB_CDEF; #2;
    tests++;
    if (rdy !== 1'b1 || sel !== 2'b10) begin
      fails++; $display("FAIL read_hit: rdy=%b sel=%b expected 1/10", rdy, sel);
    end
    tests++;
    if ({m_re, m_we, c_we} !== 3'b0) begin
      fails++; $display("FAIL read_hit_quiet: m_re/m_we/c_we=%b expected 000", {m_re, m_we, c_we});
    end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_write_hit();
    wr_t e;
    @(negedge clk); drive_idle();
    addr = 16'h0001; we = 1; wrt_data = 16'hBEEF; c_hit = 1;
    c_rd_line = 64'h4444_3333_2222_1111;
    exp_q.push_back({64'h4444_3333_BEEF_1111, 1'b1});
    #2;
    tests++;
    if (rdy !== 1'b1 || {m_re, m_we} !== 2'b0) begin
      fails++; $display("FAIL write_hit_rdy: rdy=%b mem=%b expected 1/00", rdy, {m_re, m_we});
    end
    tests++;
    if (c_we !== 1'b1) begin
      fails++; $display("FAIL write_hit_we: c_we=%b expected 1", c_we);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (c_wr_line !== e.line || c_dirty_out !== e.dirty) begin
        fails++; $display("FAIL write_hit_line: got %h/%b expected %h/%b", c_wr_line, c_dirty_out, e.line, e.dirty);
      end
    end
    exp_q.delete();
    @(negedge clk); drive_idle();
  endtask

  task automatic test_clean_read_miss();
    int re_cnt = 0;
    int rdy_cyc = -1;
    bit filled = 0;
    bit saw_we = 0;
    wr_t e;
    logic [63:0] fill = 64'hA5A5_0004_0003_0002;
    @(negedge clk); drive_idle();
    addr = 16'h3404; re = 1; c_rd_line = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      m_rdy = (re_cnt == 3);
      m_rd_data = fill;
      if (m_rdy) exp_q.push_back({fill, 1'b0});
      if (filled) begin c_hit = 1; c_rd_line = fill; end
      #2;
      if (m_we) saw_we = 1;
      if (m_re) begin
        re_cnt++;
        tests++;
        if (m_addr !== 14'h0D01) begin
          fails++; $display("FAIL clean_miss_addr: m_addr=%h expected 0d01", m_addr);
        end
      end
      if (c_we) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL clean_miss_fill: unexpected c_we line=%h expected none", c_wr_line);
        end else begin
          e = exp_q.pop_front();
          if (c_wr_line !== e.line || c_dirty_out !== e.dirty) begin
            fails++; $display("FAIL clean_miss_fill: got %h/%b expected %h/%b", c_wr_line, c_dirty_out, e.line, e.dirty);
          end
        end
      end
      if (m_rdy && m_re) filled = 1;
      if (rdy) begin rdy_cyc = cyc; break; end
    end
    tests++;
    if (re_cnt != 4 || rdy_cyc != 4 || saw_we) begin
      fails++; $display("FAIL clean_miss_timing: m_re cycles=%0d rdy cycle=%0d m_we=%b expected 4/4/0", re_cnt, rdy_cyc, saw_we);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL clean_miss_pending: %0d fills outstanding expected 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk); drive_idle();
  endtask

  task automatic test_dirty_write_miss();
    int we_cnt = 0;
    int re_cnt = 0;
    int rdy_cyc = -1;
    bit wb_done = 0;
    bit filled = 0;
    bit overlap = 0;
    wr_t e;
    logic [63:0] victim = 64'h7777_6666_5555_4444;
    logic [63:0] fill   = 64'h0F0F_1E1E_2D2D_3C3C;
    logic [63:0] merged = 64'h0F0F_1E1E_2D2D_CAFE;
    @(negedge clk); drive_idle();
    addr = 16'h3404; we = 1; wrt_data = 16'hCAFE;
    c_dirty = 1; c_tag = 8'h7F; c_rd_line = victim;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc > 0) @(negedge clk);
      m_rdy = wb_done ? (re_cnt == 1) : (we_cnt == 2);
      m_rd_data = fill;
      if (m_rdy && wb_done) exp_q.push_back({merged, 1'b1});
      if (filled) begin
        c_hit = 1; c_rd_line = merged;
        exp_q.push_back({merged, 1'b1});
      end
      #2;
      if (m_re && m_we) overlap = 1;
      if (m_we) begin
        we_cnt++;
        tests++;
        if (m_addr !== 14'h1FC1 || m_wr_data !== victim) begin
          fails++; $display("FAIL dirty_miss_wb: addr=%h data=%h expected 1fc1/%h", m_addr, m_wr_data, victim);
        end
        if (m_rdy) wb_done = 1;
      end else if (m_re) begin
        re_cnt++;
        tests++;
        if (m_addr !== 14'h0D01) begin
          fails++; $display("FAIL dirty_miss_fill_addr: m_addr=%h expected 0d01", m_addr);
        end
        if (m_rdy) filled = 1;
      end
      if (c_we) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL dirty_miss_cwe: unexpected c_we line=%h expected none", c_wr_line);
        end else begin
          e = exp_q.pop_front();
          if (c_wr_line !== e.line || c_dirty_out !== e.dirty) begin
            fails++; $display("FAIL dirty_miss_cwe: got %h/%b expected %h/%b", c_wr_line, c_dirty_out, e.line, e.dirty);
          end
        end
      end
      if (rdy) begin rdy_cyc = cyc; break; end
    end
    tests++;
    if (we_cnt != 3 || re_cnt != 2 || rdy_cyc != 5 || overlap) begin
      fails++; $display("FAIL dirty_miss_timing: we=%0d re=%0d rdy=%0d overlap=%b expected 3/2/5/0", we_cnt, re_cnt, rdy_cyc, overlap);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL dirty_miss_pending: %0d writes outstanding expected 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk); drive_idle();
  endtask

  task automatic test_zero_wait_fill();
    wr_t e;
    logic [63:0] fill = 64'h1357_9BDF_2468_ACE0;
    @(negedge clk); drive_idle();
    addr = 16'h004B; re = 1; m_rdy = 1; m_rd_data = fill; #2;
    tests++;
    if (m_re !== 1'b1 || m_addr !== 14'h0012 || c_we !== 1'b0) begin
      fails++; $display("FAIL zw_compare: m_re=%b m_addr=%h c_we=%b expected 1/0012/0", m_re, m_addr, c_we);
    end
    @(negedge clk); exp_q.push_back({fill, 1'b0}); #2;
    tests++;
    if (c_we !== 1'b1 || m_re !== 1'b1) begin
      fails++; $display("FAIL zw_fill: c_we=%b m_re=%b expected 1/1", c_we, m_re);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (c_wr_line !== e.line || c_dirty_out !== e.dirty) begin
        fails++; $display("FAIL zw_fill_line: got %h/%b expected %h/%b", c_wr_line, c_dirty_out, e.line, e.dirty);
      end
    end
    exp_q.delete();
    @(negedge clk); m_rdy = 0; c_hit = 1; c_rd_line = fill; #2;
    tests++;
    if (rdy !== 1'b1 || sel !== 2'b11 || {m_re, m_we} !== 2'b0) begin
      fails++; $display("FAIL zw_complete: rdy=%b sel=%b mem=%b expected 1/11/00", rdy, sel, {m_re, m_we});
    end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_back_to_back();
    wr_t e;
    logic [63:0] line, exp_line;
    logic [1:0]  o;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive_idle();
      line = {$urandom, $urandom};
      addr = 16'($urandom);
      o = addr[1:0];
      c_hit = 1; c_rd_line = line;
      if (i % 2 == 1) begin
        we = 1; wrt_data = 16'($urandom);
        exp_line = line;
        exp_line[o * 16 +: 16] = wrt_data;
        exp_q.push_back({exp_line, 1'b1});
      end else begin
        re = 1;
      end
      #2;
      tests++;
      if (rdy !== 1'b1 || {m_re, m_we} !== 2'b0) begin
        fails++; $display("FAIL b2b_rdy[%0d]: rdy=%b mem=%b expected 1/00", i, rdy, {m_re, m_we});
      end
      tests++;
      if (we) begin
        if (c_we !== 1'b1 || exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_write[%0d]: c_we=%b expected 1", i, c_we);
        end else begin
          e = exp_q.pop_front();
          if (c_wr_line !== e.line || c_dirty_out !== e.dirty) begin
            fails++; $display("FAIL b2b_write[%0d]: got %h/%b expected %h/%b", i, c_wr_line, c_dirty_out, e.line, e.dirty);
          end
        end
      end else if (sel !== o || c_we !== 1'b0) begin
        fails++; $display("FAIL b2b_read[%0d]: sel=%b c_we=%b expected %b/0", i, sel, c_we, o);
      end
    end
    exp_q.delete();
    @(negedge clk); drive_idle();
  endtask

  task automatic test_reset_mid_alloc();
    @(negedge clk); drive_idle();
    addr = 16'h3404; re = 1;
    @(negedge clk); #2;
    tests++;
    if (m_re !== 1'b1) begin
      fails++; $display("FAIL rst_alloc_pre: m_re=%b expected 1", m_re);
    end
    @(negedge clk); rst_n = 0; re = 0;
    @(negedge clk); rst_n = 1; #2;
    tests++;
    if ({m_re, m_we, c_we, rdy} !== 4'b0) begin
      fails++; $display("FAIL rst_alloc_post: m_re/m_we/c_we/rdy=%b expected 0000", {m_re, m_we, c_we, rdy});
    end
    @(negedge clk); drive_idle();
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic test_stats();
    @(negedge clk); rst_n = 0; drive_idle();
    @(negedge clk); rst_n = 1; #2;
    tests++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      fails++; $display("FAIL stats_reset: hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_idle(); re = 1; c_hit = 1; addr = 16'(i);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive_idle(); re = 1; addr = 16'h0100;
      @(negedge clk); m_rdy = 1;
      @(negedge clk); m_rdy = 0; c_hit = 1;
    end
    @(negedge clk); drive_idle(); #2;
    tests++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
      fails++; $display("FAIL stats_count: hit=%0d miss=%0d expected 3/2", hit_cnt, miss_cnt);
    end
    re = 1; c_hit = 1;
    repeat (65540) @(negedge clk);
    drive_idle(); #2;
    tests++;
    if (hit_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL stats_saturate: hit=%h expected ffff", hit_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_read_miss();
    test_dirty_write_miss();
    test_zero_wait_fill();
    test_back_to_back();
    test_reset_mid_alloc();
`ifdef CACHE_CTRL_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
